// File: rtl/dct8_transpose_buf.sv
// dct8_transpose_buf: ping-pong 8x8 transpose memory between the DCT row and column passes.
// Optional macro DCT8_TP_LAST_EN adds dout_last, flagging the final coefficient of each block.
module dct8_transpose_buf #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  output logic                     din_ready,
  output logic                     dout_valid,
  output logic signed [DATA_W-1:0] dout,
`ifdef DCT8_TP_LAST_EN
  output logic                     dout_last,
`endif
  input  logic                     dout_ready
);

  localparam int HALF  = DEPTH_LOG2 / 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic signed [DATA_W-1:0] mem [2][DEPTH];

  logic                  wr_bank;
  logic                  rd_bank;
  logic [DEPTH_LOG2-1:0] wr_cnt;
  logic [DEPTH_LOG2-1:0] rd_cnt;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [1:0]            bank_full;
  logic [1:0]            bank_full_nxt;
  logic                  wr_en;
  logic                  wr_last;
  logic                  load;
  logic                  rd_last;

  // din_ready depends only on registered state, never on dout_ready.
  assign din_ready = !bank_full[wr_bank];
  assign wr_en     = din_valid && din_ready;
  assign wr_last   = &wr_cnt;
  assign load      = bank_full[rd_bank] && (!dout_valid || dout_ready);
  assign rd_last   = &rd_cnt;
  // Swapping row and column fields turns the row-major store into a column-major read.
  assign rd_addr   = {rd_cnt[HALF-1:0], rd_cnt[DEPTH_LOG2-1:HALF]};

  // NOTE: combinational next-state starts from a default assignment, so no latch is inferred.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_en && wr_last) bank_full_nxt[wr_bank] = 1'b1;
    if (load && rd_last)  bank_full_nxt[rd_bank] = 1'b0;
  end

  // NOTE: the coefficient store has no reset; bank_full gates every read, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_cnt] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      bank_full  <= 2'b00;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_en) begin
        wr_cnt <= wr_cnt + DEPTH_LOG2'(1);
        if (wr_last) wr_bank <= !wr_bank;
      end
      if (load) begin
        dout       <= mem[rd_bank][rd_addr];
        dout_valid <= 1'b1;
        rd_cnt     <= rd_cnt + DEPTH_LOG2'(1);
        if (rd_last) rd_bank <= !rd_bank;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef DCT8_TP_LAST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_last <= 1'b0;
    end else if (load) begin
      dout_last <= rd_last;
    end else if (dout_ready) begin
      dout_last <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/dct8_transpose_buf.md
Name: dct8_transpose_buf

Overview:
- Ping-pong 8x8 transpose memory between the row pass and the column pass of the memory-based 2-D DCT.
- Consumes the serial coefficient stream of the streaming 8-point DCT stage: 64 coefficients per block, row-major, 8 rows of 8.
- Re-emits each block column-major, so a second 8-point DCT instance can perform the column transform.
- Two 64-entry banks allow one block to fill while the other drains, giving full throughput.

Parameters:
DATA_W, 16, coefficient width; set to DCT8_OUT_W at instantiation.
DEPTH_LOG2, 6, log2 of entries per bank; fixed at 6 (8x8), parameterised only for address sizing.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
din_valid  input  1  input coefficient valid
din  input  DATA_W (signed)  row-major coefficient from the DCT row stage
din_ready  output  1  buffer can accept din this cycle
dout_valid  output  1  output register holds a valid coefficient
dout  output  DATA_W (signed)  column-major coefficient to the column stage
dout_ready  input  1  downstream accepts dout

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset state (at the first rising edge with rst_n=0):
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00.
  - dout_valid=0, dout=0, din_ready=1 from the following cycle.
  - Memory contents are not reset.
- Storage: mem[bank][addr], 2 x 64 x DATA_W, inferred registers or RAM with asynchronous read into the output register.
- Write side:
  - din_ready = !bank_full[wr_bank], decoded from registered state only.
  - No combinational path from dout_ready to din_ready.
  - Handshake: a sample is accepted at a rising edge with din_valid && din_ready; it is written to mem[wr_bank][wr_cnt] (row = wr_cnt[5:3], col = wr_cnt[2:0]).
  - wr_cnt increments on each accept.
  - On accepting with wr_cnt==63: set bank_full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - din_valid while din_ready=0 is legal; it stalls and the sample is not consumed.
- Read side:
  - Load condition: bank_full[rd_bank] && (!dout_valid || dout_ready).
  - On load: dout <= mem[rd_bank][{rd_cnt[2:0], rd_cnt[5:3]}] (row = rd_cnt[2:0], col = rd_cnt[5:3]), dout_valid <= 1, rd_cnt increments.
  - Output order per block: (r0,c0),(r1,c0)...(r7,c0),(r0,c1)...(r7,c7).
  - On loading rd_cnt==63: clear bank_full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
  - If dout_valid && dout_ready and no load occurs, dout_valid <= 0.
  - dout and dout_valid hold stable while dout_valid && !dout_ready.
- Latency: the first coefficient of a block appears (dout_valid=1) exactly one cycle after the edge that accepted that block's 64th sample, provided the output register is free.
- Throughput: continuous din_valid=1 and dout_ready=1 sustains one sample per cycle in and out indefinitely, with din_ready never deasserted.
- Simultaneous events:
  - The read-side clear and write-side set of bank_full always target different banks; both take effect at the same edge.
  - A writer stalled on a bank the reader frees at edge E sees din_ready=1 in the cycle after E.
- Full condition: both banks full and the output register occupied means din_ready=0 until dout_ready drains the first block's final load.
- Reset mid-operation: any partial block and any queued blocks are discarded. No stale output is presented after reset.

Optional Feature:
Macro: DCT8_TP_LAST_EN.
- Defined:
  - Adds output port dout_last (1 bit), registered alongside dout.
  - dout_last=1 exactly when the loaded entry is rd_cnt==63, i.e. the final coefficient (r7,c7) of a block; 0 otherwise.
  - Reset value 0; holds under stall like dout.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Order check: after reset, send din = 0..63 with din_valid=1 and dout_ready=1. Required: dout sequence 0,8,16,...,56,1,9,...,63. The first dout_valid occurs one cycle after the 64th accept.
2. Back-to-back: send three blocks continuously (din = k, k+100, k+200 for k=0..63). Required: din_ready stays 1 throughout; 192 outputs with no bubble after the first; block 2 yields 100,108,...,163.
3. Backpressure: hold dout_ready=0 and stream din continuously. Required: din_ready falls after exactly 128 accepts; dout holds 0 stably. Releasing dout_ready drains 128 correctly ordered samples, and din_ready returns 1 one cycle after bank 0's last load.
4. Random stall: randomise din_valid and dout_ready at ~50% over 10 blocks. Required: every output matches the transpose model; no drop or duplicate.
5. Reset mid-block: accept 37 samples, then drive rst_n=0 for 1 cycle, then send a fresh block 0..63. Required: dout_valid=0 during and after reset until the new block completes; output is exactly the transpose of the new block.
6. With DCT8_TP_LAST_EN: run scenario 2. Required: dout_last=1 only on outputs 63, 163 and 263, coincident with dout_valid; 0 on all other cycles.
